// File: rtl/wb_pkg.sv
// Shared Wishbone constants for the burst master: cycle-type and burst-type
// codes, the master FSM state encoding and the beats-per-burst helper.
package wb_pkg;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR = 2'b00;
    localparam logic [1:0] WRAP4  = 2'b01;
    localparam logic [1:0] WRAP8  = 2'b10;
    localparam logic [1:0] WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wbm_state_e;

    // A LINEAR request is a single classic beat.
    function automatic logic [4:0] bte_beats(input logic [1:0] bte);
        case (bte)
            WRAP4:   return 5'd4;
            WRAP8:   return 5'd8;
            WRAP16:  return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone master-side bus bundle. Handshake: a beat transfers in any cycle
// where stb_o and ack_i are both high; ack_i with stb_o low carries no meaning.
interface wb_burst_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc_o;
    logic            stb_o;
    logic            we_o;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   dat_o;
    logic [DW/8-1:0] sel_o;
    logic [2:0]      cti_o;
    logic [1:0]      bte_o;
    logic [DW-1:0]   dat_i;
    logic            ack_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_burst_master_adr_wrap.sv
// Next beat address for a Wishbone wrap burst: the word offset advances inside
// a 4/8/16-word window while the bits above the window hold; LINEAR holds.
module wb_adr_wrap
    import wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic [AW-1:0] adr,
    input  logic [1:0]    bte,
    output logic [AW-1:0] adr_next
);
    localparam int BYTES = DW / 8;

    logic [AW-1:0] mask;
    logic [AW-1:0] inc;

    always_comb begin
        mask = '0;
        case (bte)
            WRAP4:   mask = AW'(4 * BYTES - 1);
            WRAP8:   mask = AW'(8 * BYTES - 1);
            WRAP16:  mask = AW'(16 * BYTES - 1);
            default: mask = '0;
        endcase
        inc      = adr + AW'(BYTES);
        adr_next = (adr & ~mask) | (inc & mask);
    end
endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst master: pops requests from a FWFT request FIFO and runs
// single/wrap bursts fed by a write-data FIFO or into a read-data FIFO.
// Optional bus-error handling is built when WB_MASTER_ERR_EN is defined.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            req_empty,
    output logic            req_re,
    input  logic            req_we,
    input  logic [AW-1:0]   req_adr,
    input  logic [1:0]      req_bte,
    input  logic            wdat_empty,
    output logic            wdat_re,
    input  logic [DW-1:0]   wdat,
    input  logic            rdat_full,
    output logic            rdat_we,
    output logic [DW-1:0]   rdat,
    wb_burst_master_if.master wb,
`ifdef WB_MASTER_ERR_EN
    input  logic            err_i,
    output logic            err_o,
`endif
    output logic            state_idle
);
    wbm_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d, adr_nxt;
    logic [1:0]    bte_q, bte_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          last;
    logic          cyc, stb;
    logic [2:0]    cti;
`ifdef WB_MASTER_ERR_EN
    logic          err_q, err_d;
`endif

    wb_adr_wrap #(.AW(AW), .DW(DW)) u_adr_wrap (
        .adr      (adr_q),
        .bte      (bte_q),
        .adr_next (adr_nxt)
    );

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            bte_q   <= '0;
            cnt_q   <= '0;
`ifdef WB_MASTER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            bte_q   <= bte_d;
            cnt_q   <= cnt_d;
`ifdef WB_MASTER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        bte_d   = bte_q;
        cnt_d   = cnt_q;
`ifdef WB_MASTER_ERR_EN
        err_d   = err_q;
`endif
        req_re  = 1'b0;
        wdat_re = 1'b0;
        rdat_we = 1'b0;
        cyc     = 1'b0;
        stb     = 1'b0;
        cti     = CLASSIC;
        last    = (cnt_q == 5'd1);

        case (state_q)
            IDLE: begin
                if (!req_empty) begin
                    req_re  = 1'b1;
                    we_d    = req_we;
                    adr_d   = req_adr;
                    bte_d   = req_bte;
                    cnt_d   = bte_beats(req_bte);
`ifdef WB_MASTER_ERR_EN
                    err_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                cyc = 1'b1;
                // Stall the bus rather than under-run/over-run the data FIFOs.
                stb = we_q ? !wdat_empty : !rdat_full;
                cti = (bte_q == LINEAR) ? CLASSIC : (last ? EOB : INCR);
`ifdef WB_MASTER_ERR_EN
                if (stb && err_i) begin
                    err_d   = 1'b1;
                    cnt_d   = cnt_q - 5'd1;
                    state_d = (we_q && !last) ? DRAIN : IDLE;
                end else
`endif
                if (stb && wb.ack_i) begin
                    wdat_re = we_q;
                    rdat_we = !we_q;
                    cnt_d   = cnt_q - 5'd1;
                    adr_d   = adr_nxt;
                    if (last) state_d = IDLE;
                end
            end
            DRAIN: begin
`ifdef WB_MASTER_ERR_EN
                // Discard the aborted burst's remaining write words, bus idle.
                if (!wdat_empty) begin
                    wdat_re = 1'b1;
                    cnt_d   = cnt_q - 5'd1;
                    if (last) state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (wb_rst) begin
            req_re  = 1'b0;
            wdat_re = 1'b0;
            rdat_we = 1'b0;
            cyc     = 1'b0;
            stb     = 1'b0;
            cti     = CLASSIC;
        end
    end

    assign wb.cyc_o   = cyc;
    assign wb.stb_o   = stb;
    assign wb.we_o    = we_q & cyc;
    assign wb.adr_o   = adr_q;
    assign wb.dat_o   = wdat;
    assign wb.sel_o   = cyc ? '1 : '0;
    assign wb.cti_o   = cti;
    assign wb.bte_o   = bte_q;
    assign rdat       = wb.dat_i;
    assign state_idle = (state_q == IDLE);
`ifdef WB_MASTER_ERR_EN
    assign err_o      = err_q;
`endif
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed table of bursts, hand-written reset and
// error sequences, and random bursts checked against a burst-level model.
module tb_wb_burst_master;
    import wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic wb_clk = 1'b0;
    logic wb_rst = 1'b0;
    always #5 wb_clk = ~wb_clk;

    logic          req_empty, req_re, req_we;
    logic [AW-1:0] req_adr;
    logic [1:0]    req_bte;
    logic          wdat_empty, wdat_re;
    logic [DW-1:0] wdat;
    logic          rdat_full, rdat_we;
    logic [DW-1:0] rdat;
    logic          state_idle;
`ifdef WB_MASTER_ERR_EN
    logic          err_i, err_o;
`endif

    wb_burst_master_if #(.AW(AW), .DW(DW)) wb ();

    wb_burst_master #(.AW(AW), .DW(DW)) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .req_empty  (req_empty),
        .req_re     (req_re),
        .req_we     (req_we),
        .req_adr    (req_adr),
        .req_bte    (req_bte),
        .wdat_empty (wdat_empty),
        .wdat_re    (wdat_re),
        .wdat       (wdat),
        .rdat_full  (rdat_full),
        .rdat_we    (rdat_we),
        .rdat       (rdat),
        .wb         (wb),
`ifdef WB_MASTER_ERR_EN
        .err_i      (err_i),
        .err_o      (err_o),
`endif
        .state_idle (state_idle)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        logic          we;
        logic          last;
        logic [1:0]    bte;
        logic [2:0]    cti;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } beat_t;
    localparam int EW = $bits(beat_t);

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [1:0]    bte;
    } req_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [1:0]    bte;
        int            beats;
        logic [AW-1:0] first_adr;
        logic [AW-1:0] last_adr;
        logic [2:0]    last_cti;
        int            stall_at;
        int            stall_len;
    } vec_t;

    logic [EW-1:0] exp_q[$];
    req_t          req_fifo[$];
    logic [DW-1:0] wdat_fifo[$];
    logic [DW-1:0] slave_mem [0:255];
    logic [DW-1:0] ref_mem   [0:255];

    int vectors = 0;
    int miscompares = 0;
    int ack_pct, wstall_pct, rstall_pct;
    int force_cnt, stall_at, stall_len;
    int beats_seen, wre_cnt, rwe_cnt, stalls;
    logic hold_w, hold_r;
    logic prev_final, prev_cyc, prev_beat;
    logic [AW-1:0] prev_adr, first_adr, last_adr;
    logic [2:0] last_cti;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic we, input logic [AW-1:0] adr, input logic [1:0] bte);
        int n, off;
        logic [AW-1:0] base, a;
        beat_t b;
        req_t r;
        n = (bte == 2'b00) ? 1 : (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : 16;
        off = int'(adr[9:2]) % n;
        base = adr - AW'(off * 4);
        for (int k = 0; k < n; k++) begin
            a      = base + AW'(((off + k) % n) * 4);
            b.we   = we;
            b.last = (k == n - 1);
            b.bte  = bte;
            b.cti  = (n == 1) ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010;
            b.adr  = a;
            if (we) begin
                b.data = $urandom;
                ref_mem[a[9:2]] = b.data;
                wdat_fifo.push_back(b.data);
            end else begin
                b.data = ref_mem[a[9:2]];
            end
            exp_q.push_back(b);
        end
        r.we = we; r.adr = adr; r.bte = bte;
        req_fifo.push_back(r);
    endtask

    task automatic update_inputs();
        req_empty = (req_fifo.size() == 0);
        if (!req_empty) begin
            req_we  = req_fifo[0].we;
            req_adr = req_fifo[0].adr;
            req_bte = req_fifo[0].bte;
        end
        wdat_empty = hold_w || (wdat_fifo.size() == 0);
        wdat       = (wdat_fifo.size() != 0) ? wdat_fifo[0] : '0;
        rdat_full  = hold_r;
        wb.dat_i   = slave_mem[wb.adr_o[9:2]];
    endtask

    // One clock: observe and check at the falling edge, update FIFOs/slave after the rising edge.
    task automatic step();
        beat_t e;
        logic have, beat, pop_r, pop_w;
        @(negedge wb_clk);
        have = (exp_q.size() != 0);
        e = '0;
        if (have) e = exp_q[0];
        beat = wb.stb_o && wb.ack_i;
        if (prev_final) check("cyc_after_last", wb.cyc_o, 0);
        prev_final = 1'b0;
        if (req_re) check("pop_nonempty", req_empty, 0);
        if (wb.cyc_o) begin
            check("cyc_has_work", have, 1);
            check("stb_rule", wb.stb_o, e.we ? !wdat_empty : !rdat_full);
            check("sel", wb.sel_o, {(DW/8){1'b1}});
            check("we_o", wb.we_o, e.we);
            if (!wb.stb_o) stalls++;
            if (prev_cyc && !prev_beat) check("adr_hold", wb.adr_o, prev_adr);
        end else begin
            check("stb_idle", wb.stb_o, 0);
        end
        check("wdat_re", wdat_re, beat && have && e.we);
        check("rdat_we", rdat_we, beat && have && !e.we);
        if (beat && have) begin
            check("adr", wb.adr_o, e.adr);
            check("cti", wb.cti_o, e.cti);
            check("bte", wb.bte_o, e.bte);
            if (e.we) begin
                check("dat_o", wb.dat_o, e.data);
                slave_mem[wb.adr_o[9:2]] = wb.dat_o;
                wre_cnt++;
            end else begin
                check("rdat", rdat, e.data);
                rwe_cnt++;
            end
            if (e.last) check("no_pop_on_last", req_re, 0);
            if (beats_seen == 0) first_adr = wb.adr_o;
            last_adr = wb.adr_o;
            last_cti = wb.cti_o;
            beats_seen++;
            if (beats_seen == stall_at) force_cnt = stall_len;
            prev_final = e.last;
            void'(exp_q.pop_front());
        end else if (beat) begin
            check("beat_unexpected", beat, 0);
        end
        pop_r = req_re;
        pop_w = wdat_re && (wdat_fifo.size() != 0);
        prev_cyc  = wb.cyc_o;
        prev_beat = beat;
        prev_adr  = wb.adr_o;
        @(posedge wb_clk);
        #1;
        if (pop_r && req_fifo.size() != 0) void'(req_fifo.pop_front());
        if (pop_w) void'(wdat_fifo.pop_front());
        if (force_cnt > 0) begin
            hold_w = 1'b1;
            hold_r = 1'b1;
            force_cnt--;
        end else begin
            hold_w = ($urandom_range(0, 99) < wstall_pct);
            hold_r = ($urandom_range(0, 99) < rstall_pct);
        end
        wb.ack_i = ($urandom_range(0, 99) < ack_pct);
        update_inputs();
    endtask

    task automatic run_done(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || req_fifo.size() != 0) && c < budget) begin
            step();
            c++;
        end
        check("drained", exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic clear_stats();
        beats_seen = 0; wre_cnt = 0; rwe_cnt = 0; stalls = 0;
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[6];

    initial begin
        int c;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        tbl[0] = '{1'b0, 32'h100, 2'b00, 1,  32'h100, 32'h100, 3'b000, 0, 0};
        tbl[1] = '{1'b1, 32'h108, 2'b01, 4,  32'h108, 32'h104, 3'b111, 0, 0};
        tbl[2] = '{1'b0, 32'h11C, 2'b10, 8,  32'h11C, 32'h118, 3'b111, 2, 3};
        tbl[3] = '{1'b1, 32'h13C, 2'b11, 16, 32'h13C, 32'h138, 3'b111, 7, 4};
        tbl[4] = '{1'b0, 32'h230, 2'b01, 4,  32'h230, 32'h23C, 3'b111, 0, 0};
        tbl[5] = '{1'b1, 32'h2F4, 2'b10, 8,  32'h2F4, 32'h2F0, 3'b111, 0, 0};

        ack_pct = 100; wstall_pct = 0; rstall_pct = 0;
        force_cnt = 0; stall_at = 0; stall_len = 0;
        hold_w = 1'b0; hold_r = 1'b0;
        prev_final = 1'b0; prev_cyc = 1'b0; prev_beat = 1'b0; prev_adr = '0;
        first_adr = '0; last_adr = '0; last_cti = '0;
        clear_stats();
        wb.ack_i = 1'b1; wb.dat_i = '0;
        req_we = 1'b0; req_adr = '0; req_bte = '0; wdat = '0;
        req_empty = 1'b0; wdat_empty = 1'b0; rdat_full = 1'b0;
`ifdef WB_MASTER_ERR_EN
        err_i = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end

        // Reset state, with a request pending and ack high.
        #1 wb_rst = 1'b1;
        #3;
        check("rst_cyc", wb.cyc_o, 0);
        check("rst_stb", wb.stb_o, 0);
        check("rst_req_re", req_re, 0);
        check("rst_state_idle", state_idle, 1);
        check("rst_cti", wb.cti_o, 0);
        check("rst_adr", wb.adr_o, 0);
        @(posedge wb_clk);
        #1;
        update_inputs();
        @(posedge wb_clk);
        #1 wb_rst = 1'b0;
        step();

        // Directed bursts: single, wraps, with and without FIFO stalls.
        for (int i = 0; i < 6; i++) begin
            clear_stats();
            stall_at  = tbl[i].stall_at;
            stall_len = tbl[i].stall_len;
            push_req(tbl[i].we, tbl[i].adr, tbl[i].bte);
            update_inputs();
            run_done(400);
            check("n_beats", beats_seen, tbl[i].beats);
            check("first_adr", first_adr, tbl[i].first_adr);
            check("last_adr", last_adr, tbl[i].last_adr);
            check("last_cti", last_cti, tbl[i].last_cti);
            check("fifo_ops", tbl[i].we ? wre_cnt : rwe_cnt, tbl[i].beats);
            check("stall_cycles", stalls, tbl[i].stall_len);
        end
        stall_at = 0;

        // Reset during beat 5 of a wrap8 read.
        clear_stats();
        push_req(1'b0, 32'h200, 2'b10);
        update_inputs();
        c = 0;
        while (beats_seen < 4 && c < 100) begin
            step();
            c++;
        end
        check("reached_beat5", beats_seen, 4);
        #2 wb_rst = 1'b1;
        #1;
        check("mid_rst_cyc", wb.cyc_o, 0);
        check("mid_rst_stb", wb.stb_o, 0);
        check("mid_rst_idle", state_idle, 1);
        check("mid_rst_rdat_we", rdat_we, 0);
        check("mid_rst_adr", wb.adr_o, 0);
        check("mid_rst_cti", wb.cti_o, 0);
        check("mid_rst_bte", wb.bte_o, 0);
        exp_q.delete();
        req_fifo.delete();
        wdat_fifo.delete();
        @(posedge wb_clk);
        @(posedge wb_clk);
        #1 wb_rst = 1'b0;
        prev_cyc = 1'b0; prev_final = 1'b0;
        update_inputs();
        step();
        check("post_rst_idle", state_idle, 1);

`ifdef WB_MASTER_ERR_EN
        // Bus error on beat 2 of a wrap4 write: drain the remaining two words.
        begin
            int drains;
            logic popped;
            clear_stats();
            push_req(1'b1, 32'h108, 2'b01);
            update_inputs();
            c = 0;
            while (beats_seen < 1 && c < 100) begin
                step();
                c++;
            end
            err_i = 1'b1;
            wb.ack_i = 1'b0;
            @(negedge wb_clk);
            check("err_stb", wb.stb_o, 1);
            check("err_no_pop", wdat_re, 0);
            @(posedge wb_clk);
            #1 err_i = 1'b0;
            drains = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge wb_clk);
                check("err_cyc", wb.cyc_o, 0);
                check("err_o_sticky", err_o, 1);
                popped = wdat_re && (wdat_fifo.size() != 0);
                if (wdat_re) drains++;
                @(posedge wb_clk);
                #1;
                if (popped) void'(wdat_fifo.pop_front());
                update_inputs();
            end
            check("err_drains", drains, 2);
            check("err_idle", state_idle, 1);
            exp_q.delete();
            wdat_fifo.delete();
            for (int i = 0; i < 256; i++) ref_mem[i] = slave_mem[i];
            prev_cyc = 1'b0; prev_final = 1'b0;
            push_req(1'b0, 32'h040, 2'b00);
            update_inputs();
            run_done(100);
            check("err_o_cleared", err_o, 0);
        end
`endif

        // Random bursts with random acks and FIFO stalls.
        ack_pct = 70; wstall_pct = 20; rstall_pct = 20;
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 3; k++) begin
                a = AW'($urandom_range(0, 255)) << 2;
                push_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)));
            end
            update_inputs();
            run_done(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 32, meaning Wishbone byte-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (byte lanes = DW/8).
REQ-003 wb_clk  in  1  clock; all logic is on its rising edge.
REQ-004 wb_rst  in  1  reset: asynchronous, active-high.
REQ-005 req_empty  in  1  request FIFO empty (first-word-fall-through).
REQ-006 req_re  out  1  request FIFO pop.
REQ-007 req_we  in  1  request is a write.
REQ-008 req_adr  in  AW  start byte address, word aligned.
REQ-009 req_bte  in  2  burst type: 00 single, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-010 wdat_empty  in  1  write-data FIFO empty (first-word-fall-through).
REQ-011 wdat_re  out  1  write-data FIFO pop.
REQ-012 wdat  in  DW  write-data FIFO head.
REQ-013 rdat_full  in  1  read-data FIFO full.
REQ-014 rdat_we  out  1  read-data FIFO push.
REQ-015 rdat  out  DW  read-data FIFO input.
REQ-016 cyc_o, stb_o, we_o  out  1 each  Wishbone master strobes.
REQ-017 adr_o  out  AW  Wishbone address.
REQ-018 dat_o  out  DW  Wishbone write data.
REQ-019 sel_o  out  DW/8  byte selects.
REQ-020 cti_o  out  3  cycle type identifier.
REQ-021 bte_o  out  2  burst type extension.
REQ-022 dat_i  in  DW  Wishbone read data.
REQ-023 ack_i  in  1  Wishbone acknowledge.
REQ-024 state_idle  out  1  FSM is in IDLE.

Function
REQ-025 SHALL use states IDLE, RUN, DRAIN.
REQ-026 IDLE->RUN when !req_empty:
- req_re pulses for one cycle.
- Registers we, adr, bte and beat count: single=1, wrap4=4, wrap8=8, wrap16=16.
REQ-027 In RUN:
- cyc_o=1.
- stb_o = we ? !wdat_empty : !rdat_full; stb_o low inserts master wait states.
REQ-028 Beat completes on stb_o & ack_i:
- Write: wdat_re=1; dat_o=wdat combinationally.
- Read: rdat_we=1; rdat=dat_i in the same cycle.
REQ-029 Address advance per completed beat:
- adr_o += DW/8 within the wrap window only; bits above the window are held.
- Window widths: 4, 8 or 16 words.
- Single: no advance.
REQ-030 cti_o:
- Single: 000.
- Burst: 010 on all beats except the final beat, which is 111.
- bte_o = registered bte.
REQ-031 On completion of the final beat, RUN->IDLE; cyc_o=0 in the next cycle.
- A new request SHALL NOT be popped in that same cycle (one idle cycle minimum).
REQ-032 sel_o SHALL be all ones whenever cyc_o=1.
REQ-033 ack_i while stb_o=0 SHALL be ignored: no beat, no FIFO access.
REQ-034 DRAIN is entered only under WB_MASTER_ERR_EN; see Configuration.

Reset
REQ-035 Asserting wb_rst at any time SHALL force IDLE and clear all of the following to 0 immediately, including mid-burst: cyc_o, stb_o, we_o, req_re, wdat_re, rdat_we, cti_o, bte_o, adr_o, beat count.
REQ-036 state_idle SHALL be 1 during reset.

Configuration
REQ-037 With WB_MASTER_ERR_EN defined:
- Input err_i (1 bit) and output err_o (1 bit) exist.
- stb_o & err_i terminates the beat with no FIFO access, drops cyc_o next cycle, and sets err_o.
- err_o is sticky until the next req_re.
- Write bursts: enter DRAIN and pop the remaining beats of the burst (wdat_re while !wdat_empty, bus idle), then go to IDLE.
- Read bursts: go directly to IDLE with nothing pushed.
REQ-038 Without WB_MASTER_ERR_EN:
- err_i and err_o are absent.
- DRAIN is unreachable.

Structure
REQ-039 Shared package wb_pkg SHALL hold:
- cti constants: CLASSIC=000, INCR=010, EOB=111.
- bte constants: LINEAR, WRAP4, WRAP8, WRAP16.
- The state encoding.
REQ-040 Address wrap/increment logic SHALL be a sub-module, wb_adr_wrap.
- Inputs: adr, bte. Output: next adr.

Verification
REQ-041 Single read, adr 0x100, slave acks in 1 cycle -> cti 000, one rdat_we with dat_i, cyc_o low next cycle.
REQ-042 wrap4 write at 0x108 with 4 words queued -> adr_o 0x108,0x10C,0x100,0x104; cti 010,010,010,111; 4 wdat_re.
REQ-043 wrap8 read with rdat_full high for 3 cycles after beat 2 -> stb_o low for 3 cycles, adr_o held, 8 pushes total, no loss.
REQ-044 wrap16 write, wdat_empty high mid-burst -> stb_o low while empty, burst resumes, exactly 16 wdat_re.
REQ-045 wb_rst asserted at beat 5 of a wrap8 -> cyc_o/stb_o low same cycle, state_idle=1.
REQ-046 With WB_MASTER_ERR_EN: err_i on beat 2 of a wrap4 write -> err_o=1, 2 remaining beats drained from the FIFO, IDLE, err_o cleared at the next req_re.
